// File: rtl/rx_frame_fifo.sv
// Store-and-forward AXI-S receive FIFO: the read side sees a frame only after its last beat commits.
// Optional build macro RX_DROP_BAD_FRAME_EN discards FCS-bad frames instead of committing a marker.
module rx_frame_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned KEEP_W     = DATA_W / 8,
  parameter int unsigned DEPTH_LOG2 = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       rx_axis_resetn,
  input  logic [DATA_W-1:0]          rx_axis_tdata,
  input  logic [KEEP_W-1:0]          rx_axis_tkeep,
  input  logic                       rx_axis_tvalid,
  input  logic                       rx_axis_tuser,
  input  logic                       rx_axis_tlast,
  output logic [DATA_W+KEEP_W:0]     pipe_write_data,
  output logic                       pipe_write_req,
  input  logic                       pipe_write_ack,
  output logic [CNT_W-1:0]           frames_committed,
  output logic [CNT_W-1:0]           frames_dropped,
  output logic [DEPTH_LOG2:0]        fifo_level
);

  localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = 1 + DATA_W + KEEP_W;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   committed_q, dropped_q;
  logic               resetn_q;

  logic               full;
  logic               mem_we;
  logic [ENTRY_W-1:0] mem_wdata;
  logic               commit_inc;
  logic               drop_inc;

  assign fifo_level       = wr_ptr_q - rd_ptr_q;
  // Level never exceeds DEPTH, so its MSB alone marks the full condition.
  assign full             = fifo_level[DEPTH_LOG2];
  assign pipe_write_req   = (rd_ptr_q != commit_ptr_q);
  assign pipe_write_data  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign frames_committed = committed_q;
  assign frames_dropped   = dropped_q;
  assign rx_axis_resetn   = resetn_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (pipe_write_req && pipe_write_ack) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    mem_wdata    = {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};
    commit_inc   = 1'b0;
    drop_inc     = 1'b0;
    if (rx_axis_tvalid) begin
      case (state_q)
        StIdle, StRecv: begin
          if (full) begin
            // No room: throw away everything written for this frame so far.
            wr_ptr_d = commit_ptr_q;
            if (rx_axis_tlast) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d  = StDrop;
            end
          end else if (!rx_axis_tlast) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            state_d  = StRecv;
          end else if (rx_axis_tuser) begin
            mem_we       = 1'b1;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            commit_ptr_d = wr_ptr_q + PTR_W'(1);
            commit_inc   = 1'b1;
            state_d      = StIdle;
          end else begin
`ifdef RX_DROP_BAD_FRAME_EN
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = StIdle;
`else
            // Bad FCS is forwarded as a marker entry so the consumer can abort the frame.
            mem_we       = 1'b1;
            mem_wdata    = {1'b1, DATA_W'(1), KEEP_W'(0)};
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            commit_ptr_d = wr_ptr_q + PTR_W'(1);
            commit_inc   = 1'b1;
            state_d      = StIdle;
`endif
          end
        end
        StDrop: begin
          if (rx_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      state_q      <= StIdle;
      committed_q  <= '0;
      dropped_q    <= '0;
      resetn_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      resetn_q     <= 1'b1;
      if (commit_inc && (committed_q != '1)) begin
        committed_q <= committed_q + CNT_W'(1);
      end
      if (drop_inc && (dropped_q != '1)) begin
        dropped_q <= dropped_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: directed vector table, corner sequences, and randomized traffic
// checked against a queue-based model of committed and pending frame contents.
module tb_rx_frame_fifo;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DL    = 7;
  localparam int CW    = 16;
  localparam int EW    = 1 + DW + KW;
  localparam int DEPTH = 128;

  logic          clk;
  logic          reset;
  logic          rx_axis_resetn;
  logic [DW-1:0] rx_axis_tdata;
  logic [KW-1:0] rx_axis_tkeep;
  logic          rx_axis_tvalid;
  logic          rx_axis_tuser;
  logic          rx_axis_tlast;
  logic [EW-1:0] pipe_write_data;
  logic          pipe_write_req;
  logic          pipe_write_ack;
  logic [CW-1:0] frames_committed;
  logic [CW-1:0] frames_dropped;
  logic [DL:0]   fifo_level;

  rx_frame_fifo #(
    .DATA_W     (DW),
    .KEEP_W     (KW),
    .DEPTH_LOG2 (DL),
    .CNT_W      (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_axis_resetn   (rx_axis_resetn),
    .rx_axis_tdata    (rx_axis_tdata),
    .rx_axis_tkeep    (rx_axis_tkeep),
    .rx_axis_tvalid   (rx_axis_tvalid),
    .rx_axis_tuser    (rx_axis_tuser),
    .rx_axis_tlast    (rx_axis_tlast),
    .pipe_write_data  (pipe_write_data),
    .pipe_write_req   (pipe_write_req),
    .pipe_write_ack   (pipe_write_ack),
    .frames_committed (frames_committed),
    .frames_dropped   (frames_dropped),
    .fifo_level       (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: vis holds committed unread entries, pend the frame currently being received.
  logic [EW-1:0] vis[$];
  logic [EW-1:0] pend[$];
  bit            m_dropping;
  int            m_comm;
  int            m_drops;
  bit            m_resetn;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          u;
    logic          a;
    logic          er;
    int            elvl;
    logic [EW-1:0] ed;
  } vec_t;

  vec_t vecs[8];

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int            occ;
    logic [EW-1:0] ent;
    if (reset) begin
      vis.delete();
      pend.delete();
      m_dropping = 0;
      m_comm     = 0;
      m_drops    = 0;
      m_resetn   = 0;
      return;
    end
    m_resetn = 1;
    occ = vis.size() + pend.size();
    if (pipe_write_ack && vis.size() != 0) void'(vis.pop_front());
    if (!rx_axis_tvalid) return;
    ent = {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};
    if (m_dropping) begin
      if (rx_axis_tlast) begin
        m_dropping = 0;
        m_drops    = sat_inc(m_drops);
      end
    end else if (occ == DEPTH) begin
      pend.delete();
      if (rx_axis_tlast) m_drops = sat_inc(m_drops);
      else m_dropping = 1;
    end else if (!rx_axis_tlast) begin
      pend.push_back(ent);
    end else begin
      if (!rx_axis_tuser) begin
`ifdef RX_DROP_BAD_FRAME_EN
        pend.delete();
        m_drops = sat_inc(m_drops);
        return;
`else
        ent = {1'b1, DW'(1), KW'(0)};
`endif
      end
      pend.push_back(ent);
      foreach (pend[i]) vis.push_back(pend[i]);
      pend.delete();
      m_comm = sat_inc(m_comm);
    end
  endtask

  task automatic check_model();
    check("resetn", 64'(rx_axis_resetn), 64'(m_resetn));
    check("req", 64'(pipe_write_req), 64'(vis.size() != 0));
    if (vis.size() != 0) check("data", 64'(pipe_write_data), 64'(vis[0]));
    check("level", 64'(fifo_level), 64'(vis.size() + pend.size()));
    check("committed", 64'(frames_committed), 64'(m_comm));
    check("dropped", 64'(frames_dropped), 64'(m_drops));
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic u, input logic l, input logic a, input logic r);
    rx_axis_tvalid = v;
    rx_axis_tdata  = d;
    rx_axis_tkeep  = k;
    rx_axis_tuser  = u;
    rx_axis_tlast  = l;
    pipe_write_ack = a;
    reset          = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0, a, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] base, input logic u,
                            input logic a);
    for (int i = 0; i < len; i++) begin
      tick(1'b1, base + DW'(i), 4'hF, (i == len - 1) ? u : 1'b0, i == len - 1, a, 1'b0);
    end
  endtask

  initial begin
    int   rem;
    bit   ack_t;
    logic u;
    logic v;
    checks     = 0;
    errors     = 0;
    m_dropping = 0;
    m_comm     = 0;
    m_drops    = 0;
    m_resetn   = 0;

    // Reset state
    do_reset();
    check("rst_req", 64'(pipe_write_req), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_resetn", 64'(rx_axis_resetn), 64'd0);
    idle(1, 1'b0);
    check("resetn_rise", 64'(rx_axis_resetn), 64'd1);

    // 4-beat good frame with ack held high
    vecs[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 1, '0};
    vecs[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 2, '0};
    vecs[2] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 3, '0};
    vecs[3] = '{1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1, 1'b1, 4, {1'b0, 32'h11111111, 4'hF}};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3, {1'b0, 32'h22222222, 4'hF}};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2, {1'b0, 32'h33333333, 4'hF}};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1, {1'b1, 32'h44444444, 4'hF}};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0};
    foreach (vecs[i]) begin
      tick(vecs[i].v, vecs[i].d, 4'hF, vecs[i].u, vecs[i].l, vecs[i].a, 1'b0);
      check("vec_req", 64'(pipe_write_req), 64'(vecs[i].er));
      check("vec_level", 64'(fifo_level), 64'(vecs[i].elvl));
      if (vecs[i].er) check("vec_data", 64'(pipe_write_data), 64'(vecs[i].ed));
    end
    check("vec_committed", 64'(frames_committed), 64'd1);

    // Fill with 3-beat frames, ack low; the 43rd frame overflows and is rewound
    do_reset();
    for (int f = 0; f < 43; f++) send_frame(3, DW'(f << 8), 1'b1, 1'b0);
    check("fill_level", 64'(fifo_level), 64'd126);
    check("fill_dropped", 64'(frames_dropped), 64'd1);
    check("fill_committed", 64'(frames_committed), 64'd42);
    idle(130, 1'b1);
    check("fill_drained", 64'(fifo_level), 64'd0);

    // Frame longer than the FIFO into an empty FIFO
    do_reset();
    send_frame(200, 32'h00C0_0000, 1'b1, 1'b1);
    check("long_level", 64'(fifo_level), 64'd0);
    check("long_dropped", 64'(frames_dropped), 64'd1);
    check("long_req", 64'(pipe_write_req), 64'd0);

    // Bad-FCS frame
    do_reset();
    tick(1'b1, 32'hAAAA0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'hBBBB0002, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RX_DROP_BAD_FRAME_EN
    check("bad_req", 64'(pipe_write_req), 64'd0);
    check("bad_dropped", 64'(frames_dropped), 64'd1);
    check("bad_level", 64'(fifo_level), 64'd0);
`else
    check("bad_req", 64'(pipe_write_req), 64'd1);
    check("bad_committed", 64'(frames_committed), 64'd1);
    check("bad_beat1", 64'(pipe_write_data), 64'({1'b0, 32'hAAAA0001, 4'hF}));
    idle(1, 1'b1);
    check("bad_marker", 64'(pipe_write_data), 64'({1'b1, 32'h00000001, 4'h0}));
    idle(1, 1'b1);
`endif

    // Reset pulse during beat 3 of 5 with a committed frame pending
    do_reset();
    send_frame(2, 32'h500, 1'b1, 1'b0);
    tick(1'b1, 32'h601, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h602, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h603, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_req", 64'(pipe_write_req), 64'd0);
    check("mid_level", 64'(fifo_level), 64'd0);
    check("mid_committed", 64'(frames_committed), 64'd0);
    check("mid_resetn", 64'(rx_axis_resetn), 64'd0);
    idle(1, 1'b0);
    check("mid_resetn_up", 64'(rx_axis_resetn), 64'd1);
    send_frame(3, 32'h700, 1'b1, 1'b0);
    check("mid_next_req", 64'(pipe_write_req), 64'd1);
    check("mid_next_data", 64'(pipe_write_data), 64'({1'b0, 32'h700, 4'hF}));
    idle(4, 1'b1);
    check("mid_next_level", 64'(fifo_level), 64'd0);

    // Back-to-back frames, write every cycle, ack toggling
    do_reset();
    rem   = 0;
    ack_t = 0;
    u     = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (rem == 0) begin
        rem = $urandom_range(1, 8);
        u   = ($urandom_range(0, 5) != 0);
      end
      ack_t = ~ack_t;
      tick(1'b1, $urandom, KW'($urandom), (rem == 1) ? u : 1'b0, rem == 1, ack_t, 1'b0);
      rem--;
    end

    // Random valid/ack gaps, occasional oversize frames and resets
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 9) < 7);
      if (v && rem == 0) begin
        rem = ($urandom_range(0, 19) == 0) ? $urandom_range(120, 160) : $urandom_range(1, 8);
        u   = ($urandom_range(0, 5) != 0);
      end
      tick(v, $urandom, KW'($urandom), (v && rem == 1) ? u : 1'b0, v && rem == 1,
           1'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));
      if (v) rem--;
    end
    while (rem > 0) begin
      tick(1'b1, $urandom, 4'hF, 1'b1, rem == 1, 1'b1, 1'b0);
      rem--;
    end
    idle(140, 1'b1);
    check("final_level", 64'(fifo_level), 64'd0);
    check("final_req", 64'(pipe_write_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 Parameter DATA_W, default 32: AXI-S data width in bits; a multiple of 8.
REQ-002 Parameter KEEP_W, default DATA_W/8: tkeep width.
REQ-003 Parameter DEPTH_LOG2, default 7: FIFO depth is 2^DEPTH_LOG2 entries.
REQ-004 Parameter CNT_W, default 16: width of the status counters.
REQ-005 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 rx_axis_resetn  out  1  registered active-low reset to the MAC rx path.
REQ-009 rx_axis_tdata  in  DATA_W  beat data.
REQ-010 rx_axis_tkeep  in  KEEP_W  byte enables.
REQ-011 rx_axis_tvalid  in  1  beat valid; there is no tready, so the source cannot be stalled.
REQ-012 rx_axis_tuser  in  1  sampled on the tlast beat: 1 means FCS good, 0 means FCS bad.
REQ-013 rx_axis_tlast  in  1  last beat of a frame.
REQ-014 pipe_write_data  out  1+DATA_W+KEEP_W  entry {tlast, tdata, tkeep} at the read pointer.
REQ-015 pipe_write_req  out  1  entry available.
REQ-016 pipe_write_ack  in  1  consumer accepts the entry.
REQ-017 frames_committed  out  CNT_W  frames made visible to the pipe.
REQ-018 frames_dropped  out  CNT_W  frames discarded.
REQ-019 fifo_level  out  DEPTH_LOG2+1  entries written and not yet read, committed or not.

Function
REQ-020 Pointers wr_ptr, commit_ptr and rd_ptr SHALL be DEPTH_LOG2+1 bits wide; the low DEPTH_LOG2 bits address the memory and the MSB distinguishes full from empty.
REQ-021 The FIFO is full when wr_ptr - rd_ptr == 2^DEPTH_LOG2.
REQ-022 Store-and-forward: the read side SHALL see only committed entries; pipe_write_req = (rd_ptr != commit_ptr), combinational from registers.
REQ-023 pipe_write_data SHALL equal mem[rd_ptr] whenever pipe_write_req=1; asynchronous memory read.
REQ-024 A transfer occurs when pipe_write_req=1 and pipe_write_ack=1 in the same cycle; rd_ptr then increments by 1.
REQ-025 An ack while pipe_write_req=0 SHALL be ignored.
REQ-026 The write-side state machine has three states: IDLE (between frames), RECV (frame in progress) and DROP (discarding the rest of a frame).
REQ-027 IDLE/RECV, tvalid=1, not full: write the entry at wr_ptr and increment wr_ptr.
   - if tlast=0: go to RECV.
   - if tlast=1: go to IDLE and apply the end-of-frame rules.
REQ-028 End of frame with tuser=1: commit_ptr <= wr_ptr+1 and frames_committed increments; the frame is readable on the next cycle (write-to-req latency is 1 cycle).
REQ-029 End of frame with tuser=0: per REQ-041/REQ-042.
REQ-030 IDLE/RECV, tvalid=1, full: wr_ptr <= commit_ptr (rewind) and the beat is discarded.
   - if tlast=1: frames_dropped increments and the state becomes IDLE.
   - otherwise: go to DROP.
REQ-031 DROP: all beats SHALL be discarded; on tlast, frames_dropped increments and the state becomes IDLE.
REQ-032 A frame longer than 2^DEPTH_LOG2 beats SHALL always be dropped; it SHALL never deadlock.
REQ-033 A simultaneous write and read SHALL both take effect in the same cycle; fullness is evaluated on pre-read pointers.
REQ-034 A read and a commit in the same cycle SHALL both take effect.
REQ-035 Counters SHALL saturate at all-ones.
REQ-036 fifo_level = wr_ptr - rd_ptr, registered pointers only.
REQ-037 Pointer wrap-around SHALL be modulo 2^(DEPTH_LOG2+1) with no special handling.

Reset
REQ-038 While reset=1 at a clock edge, the following SHALL be cleared on that edge:
   - all pointers to 0;
   - state to IDLE;
   - both counters to 0;
   - rx_axis_resetn to 0.
   On the first edge with reset=0, rx_axis_resetn SHALL become 1.
REQ-039 Reset mid-frame SHALL discard the partial frame and all committed entries.
   - pipe_write_req SHALL be 0 from the first edge with reset=1.
   - Beats arriving while reset=1 SHALL be ignored.
REQ-040 Memory contents are not reset; pipe_write_data is don't-care while pipe_write_req=0.

Configuration
REQ-041 With macro RX_DROP_BAD_FRAME_EN defined, a tlast beat with tuser=0 SHALL:
   - not be written;
   - rewind wr_ptr to commit_ptr;
   - increment frames_dropped;
   - move the state to IDLE.
REQ-042 Without RX_DROP_BAD_FRAME_EN, a tlast beat with tuser=0 SHALL be written as the marker {1'b1, DATA_W'd1, KEEP_W'd0} and committed as in REQ-028, with frames_committed incremented.

Verification
REQ-043 Defaults; 4-beat good frame (tdata 0x11111111..0x44444444, tkeep 0xF, tuser=1 on last), ack held 1 -> pipe_write_req rises the cycle after tlast; 4 transfers in order, the last with MSB=1; frames_committed=1.
REQ-044 Ack held 0 while 3-beat frames are sent until the FIFO fills at 128 entries -> the overflowing frame is rewound; frames_dropped=1; fifo_level returns to the last committed boundary; earlier frames are read back intact.
REQ-045 200-beat frame into an empty FIFO -> frame dropped, frames_dropped=1, pipe_write_req stays 0, fifo_level=0 after tlast.
REQ-046 2-beat frame with tuser=0 on last -> with RX_DROP_BAD_FRAME_EN: nothing readable, frames_dropped=1; without it: beat 1 plus marker {1, 0x00000001, 0x0}, frames_committed=1.
REQ-047 reset pulsed for 1 cycle during beat 3 of 5 with one committed frame pending -> pipe_write_req=0, fifo_level=0, counters=0, rx_axis_resetn low for 1 cycle; the next good frame passes normally.
REQ-048 Continuous back-to-back frames with ack toggling every cycle and a write in every cycle -> no lost or duplicated entries; fifo_level stays consistent with the scoreboard.
